hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline controller for the 5-stage GPU core (IF/ID/EX/MEM/WB). It drives the PC
//   stall/stop inputs and the IF/ID and ID/EX flush inputs, which are currently tied to 0.
//   - Register scoreboard stalls ID on RAW hazards (the core has no forwarding).
//   - Squashes wrong-path instructions when EX resolves a taken branch.
//   - Sequences HALT: stop fetch, drain the pipe, then park in HALTED.
// PARAMETERS
//   NREG        16  architectural registers (4-bit specifiers)
//   ZERO_REG    1   1: r0 is never marked busy and never causes a hazard
//   WB_BYPASS   1   1: a register written by WB this cycle is readable in ID this cycle
//   DRAIN_CYC   3   cycles after HALT issues before HALTED may be entered (EX, MEM, WB)
// PORTS
//   clk             in   1   clock
//   rst             in   1   synchronous active-high reset
//   id_valid        in   1   ID holds a real instruction (not a bubble)
//   id_rs1/2/3      in   4   source specifiers in ID
//   id_rs_used      in   3   per-source read enable, bit0=rs1, bit1=rs2, bit2=rs3
//   id_rd           in   4   destination specifier in ID
//   id_reg_write_en in   1   ID instruction writes id_rd
//   id_stop         in   1   ID instruction is HALT
//   branch_taken_ex in   1   EX resolved a taken branch this cycle
//   wb_reg_write_en in   1   WB writes the register file this cycle
//   wb_rd           in   4   WB destination
//   stall           out  1   hold PC and IF/ID
//   flush_if_id     out  1   zero IF/ID at next edge
//   bubble_id_ex    out  1   load a bubble into ID/EX at next edge
//   stop            out  1   freeze PC (HALT)
//   halted          out  1   pipeline fully drained after HALT
//   busy_regs       out  16  scoreboard, bit i = write to ri pending
//   stall_cnt       out  16  saturating count of stall cycles
// BEHAVIOUR
//   - FSM states: RUN, DRAIN, HALTED.
//   - Reset: state=RUN, busy_regs=0, stall_cnt=0, drain counter=0.
//     While rst=1, all control outputs and halted are 0.
//   - hazard: some source i with id_rs_used[i]=1 has busy_regs[rs_i]=1, unless:
//       - WB_BYPASS=1 and wb_reg_write_en=1 with wb_rd==rs_i this cycle, or
//       - ZERO_REG=1 and rs_i==0.
//   - RUN, all outputs combinational, same cycle:
//       - stall = id_valid & hazard & ~branch_taken_ex.
//       - flush_if_id = branch_taken_ex.
//       - bubble_id_ex = stall | branch_taken_ex.
//       - Branch flush has priority over stall.
//   - issue = RUN & id_valid & ~stall & ~branch_taken_ex.
//   - Scoreboard, updated at the clock edge:
//       - set busy[id_rd] when issue & id_reg_write_en (and id_rd!=0 if ZERO_REG).
//       - clear busy[wb_rd] when wb_reg_write_en.
//       - Set and clear of the same register in one cycle: set wins.
//   - RUN->DRAIN when issue & id_stop:
//       - HALT flows on as a non-writing instruction.
//       - The drain counter is loaded with DRAIN_CYC.
//   - A HALT squashed by branch_taken_ex does not leave RUN.
//   - DRAIN: stop=1, flush_if_id=1, bubble_id_ex=1, stall=0.
//       - Counter decrements each cycle, saturating at 0.
//       - WB clears continue.
//       - branch_taken_ex is ignored.
//   - DRAIN->HALTED when counter==0 and busy_regs==0.
//   - HALTED: stop=1, halted=1, flush_if_id=1, bubble_id_ex=1.
//       - Left only by rst; rst mid-DRAIN or in HALTED returns to RUN next cycle.
//   - stall_cnt increments every cycle stall=1 and saturates at 16'hFFFF.
// TESTING
//   - RAW: cycle t ADD r3 issues; dependent reads r3 in ID at t+1; WB r3 at t+3
//       -> stall=1 at t+1,t+2; issues t+3; stall_cnt=2.
//       With WB_BYPASS=0 -> 3 stall cycles.
//   - Branch squash: branch_taken_ex=1 while ID holds hazarding write to r5
//       -> flush_if_id=1, bubble_id_ex=1, stall=0, busy_regs[5]=0 after the edge.
//   - Set/clear race: WB writes r4 while ID issues a write to r4 -> busy_regs[4]=1.
//   - HALT drain: id_stop issues with r7 pending, r7 WB 2 cycles later
//       -> stop=1 from the next cycle; halted=1 after 3 DRAIN cycles.
//       halted=1 persists for 20 cycles.
//   - HALT squash: id_stop and branch_taken_ex in the same cycle -> state stays RUN, stop=0.
//   - Reset mid-DRAIN -> next cycle stop=0, halted=0, busy_regs=0, stall_cnt=0.
//       r0 write/read with ZERO_REG=1 -> never stalls.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB).
// It keeps a register scoreboard and stalls ID on RAW hazards, since the core has no forwarding.
// It squashes wrong-path instructions when EX resolves a taken branch.
// It sequences HALT: stop fetch, drain the pipe, then park in HALTED until reset.
module hazard_ctrl #(
   parameter int NREG      = 16,
   parameter bit ZERO_REG  = 1'b1,
   parameter bit WB_BYPASS = 1'b1,
   parameter int DRAIN_CYC = 3,
   localparam int RW       = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [RW-1:0]   id_rs1,
   input  logic [RW-1:0]   id_rs2,
   input  logic [RW-1:0]   id_rs3,
   input  logic [2:0]      id_rs_used,
   input  logic [RW-1:0]   id_rd,
   input  logic            id_reg_write_en,
   input  logic            id_stop,
   input  logic            branch_taken_ex,
   input  logic            wb_reg_write_en,
   input  logic [RW-1:0]   wb_rd,
   output logic            stall,
   output logic            flush_if_id,
   output logic            bubble_id_ex,
   output logic            stop,
   output logic            halted,
   output logic [NREG-1:0] busy_regs,
   output logic [15:0]     stall_cnt
);

   localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
   localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYC);

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DCW-1:0]   r_drain_cnt;
   logic [DCW-1:0]   w_drain_nxt;
   logic [NREG-1:0]  r_busy;
   logic [NREG-1:0]  w_busy_nxt;
   logic [15:0]      r_stall_cnt;

   logic [2:0][RW-1:0] w_rs;
   logic w_hazard;
   logic w_issue;
   logic w_set;
   logic w_stall;
   logic w_flush;
   logic w_bubble;
   logic w_stop;
   logic w_halted;

   assign w_rs = {id_rs3, id_rs2, id_rs1};

   // RAW detection: any enabled source whose register still has a write in flight.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_hazard = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (id_rs_used[i] && r_busy[w_rs[i]]
             && !(WB_BYPASS && wb_reg_write_en && (wb_rd == w_rs[i]))
             && !(ZERO_REG && (w_rs[i] == '0)))
            w_hazard = 1'b1;
      end
   end

   // Next-state and control outputs for RUN / DRAIN / HALTED.
   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain_cnt;
      w_stall     = 1'b0;
      w_flush     = 1'b0;
      w_bubble    = 1'b0;
      w_stop      = 1'b0;
      w_halted    = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         S_RUN: begin
            // Branch flush outranks the stall: the stalled instruction is on the wrong path anyway.
            w_stall  = id_valid & w_hazard & ~branch_taken_ex;
            w_flush  = branch_taken_ex;
            w_bubble = w_stall | branch_taken_ex;
            w_issue  = id_valid & ~w_stall & ~branch_taken_ex;
            if (w_issue && id_stop) begin
               w_state_nxt = S_DRAIN;
               w_drain_nxt = DRAIN_LOAD;
            end
         end
         S_DRAIN: begin
            w_stop      = 1'b1;
            w_flush     = 1'b1;
            w_bubble    = 1'b1;
            w_drain_nxt = (r_drain_cnt != '0) ? r_drain_cnt - 1'b1 : '0;
            // The counter holds the drain cycles still owed including this one, so the
            // pipe is empty once the decremented value reaches zero.
            if ((w_drain_nxt == '0) && (r_busy == '0))
               w_state_nxt = S_HALTED;
         end
         S_HALTED: begin
            w_stop   = 1'b1;
            w_halted = 1'b1;
            w_flush  = 1'b1;
            w_bubble = 1'b1;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // HALT travels down the pipe as a non-writing instruction; r0 is never tracked.
   assign w_set = w_issue & id_reg_write_en & ~id_stop & (!ZERO_REG || (id_rd != '0));

   // Scoreboard update: WB clears, issue sets; a same-register set wins over the clear.
   always_comb begin
      w_busy_nxt = r_busy;
      if (wb_reg_write_en)
         w_busy_nxt[wb_rd] = 1'b0;
      if (w_set)
         w_busy_nxt[id_rd] = 1'b1;
   end

   // FSM state register with drain counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state     <= S_RUN;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   // Scoreboard and saturating stall counter.
   always_ff @(posedge clk) begin
      // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like any other control state.
      if (rst) begin
         r_busy      <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   // Control outputs are forced low while reset is held.
   assign stall        = w_stall  & ~rst;
   assign flush_if_id  = w_flush  & ~rst;
   assign bubble_id_ex = w_bubble & ~rst;
   assign stop         = w_stop   & ~rst;
   assign halted       = w_halted & ~rst;
   assign busy_regs    = r_busy;
   assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RAW stalls, source masking, branch squash,
// scoreboard set/clear race, HALT drain/squash, and reset out of DRAIN/HALTED.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_rs1, id_rs2, id_rs3;
   logic [2:0]  id_rs_used;
   logic [3:0]  id_rd;
   logic        id_reg_write_en;
   logic        id_stop;
   logic        branch_taken_ex;
   logic        wb_reg_write_en;
   logic [3:0]  wb_rd;
   logic        stall, flush_if_id, bubble_id_ex, stop, halted;
   logic [15:0] busy_regs;
   logic [15:0] stall_cnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   hazard_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rs3          (id_rs3),
      .id_rs_used      (id_rs_used),
      .id_rd           (id_rd),
      .id_reg_write_en (id_reg_write_en),
      .id_stop         (id_stop),
      .branch_taken_ex (branch_taken_ex),
      .wb_reg_write_en (wb_reg_write_en),
      .wb_rd           (wb_rd),
      .stall           (stall),
      .flush_if_id     (flush_if_id),
      .bubble_id_ex    (bubble_id_ex),
      .stop            (stop),
      .halted          (halted),
      .busy_regs       (busy_regs),
      .stall_cnt       (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      id_valid        = 1'b0;
      id_rs1          = '0;
      id_rs2          = '0;
      id_rs3          = '0;
      id_rs_used      = '0;
      id_rd           = '0;
      id_reg_write_en = 1'b0;
      id_stop         = 1'b0;
      branch_taken_ex = 1'b0;
      wb_reg_write_en = 1'b0;
      wb_rd           = '0;
   endtask

   task automatic id_in(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] r3, input logic [2:0] used, input logic [3:0] rd,
                        input logic we, input logic stp);
      id_valid        = v;
      id_rs1          = r1;
      id_rs2          = r2;
      id_rs3          = r3;
      id_rs_used      = used;
      id_rd           = rd;
      id_reg_write_en = we;
      id_stop         = stp;
   endtask

   task automatic wb_in(input logic [3:0] rd);
      wb_reg_write_en = 1'b1;
      wb_rd           = rd;
   endtask

   // Take one clock edge and land 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- reset: outputs low even with branch/HALT/valid asserted
      clr_in();
      rst = 1'b1;
      branch_taken_ex = 1'b1;
      id_valid = 1'b1;
      id_stop = 1'b1;
      step();
      check("rst_stall", stall, 0);
      check("rst_flush", flush_if_id, 0);
      check("rst_bubble", bubble_id_ex, 0);
      check("rst_stop", stop, 0);
      check("rst_halted", halted, 0);
      step();
      check("rst_busy", busy_regs, 16'h0000);
      check("rst_stall_cnt", stall_cnt, 0);
      rst = 1'b0;
      clr_in();
      #2;
      check("run_idle_flush", flush_if_id, 0);
      check("run_idle_stop", stop, 0);

      // ---- RAW on r3 with WB bypass: 2 stall cycles
      id_in(1, 0, 0, 0, 3'b000, 3, 1, 0);
      #2 check("raw_producer_stall", stall, 0);
      step();
      check("raw_busy_r3", busy_regs, 16'h0008);
      id_in(1, 3, 0, 0, 3'b001, 6, 1, 0);
      #2;
      check("raw_t1_stall", stall, 1);
      check("raw_t1_bubble", bubble_id_ex, 1);
      check("raw_t1_flush", flush_if_id, 0);
      step();
      check("raw_cnt1", stall_cnt, 1);
      #2 check("raw_t2_stall", stall, 1);
      step();
      check("raw_cnt2", stall_cnt, 2);
      wb_in(3);
      #2;
      check("raw_t3_bypass_stall", stall, 0);
      check("raw_t3_bubble", bubble_id_ex, 0);
      step();
      check("raw_busy_after", busy_regs, 16'h0040);
      check("raw_cnt_final", stall_cnt, 2);
      clr_in();
      wb_in(6);
      step();
      clr_in();
      check("raw_busy_clear", busy_regs, 16'h0000);

      // ---- r0 is never tracked and never hazards
      id_in(1, 0, 0, 0, 3'b000, 0, 1, 0);
      #2 check("r0_write_stall", stall, 0);
      step();
      check("r0_not_busy", busy_regs, 16'h0000);
      id_in(1, 0, 0, 0, 3'b111, 5, 0, 0);
      #2 check("r0_read_stall", stall, 0);
      step();

      // ---- per-source enables on rs2/rs3, bubble in ID
      id_in(1, 0, 0, 0, 3'b000, 9, 1, 0);
      step();
      check("src_busy_r9", busy_regs, 16'h0200);
      id_in(1, 0, 9, 0, 3'b010, 1, 0, 0);
      #2 check("src_rs2_stall", stall, 1);
      step();
      id_in(1, 0, 0, 9, 3'b100, 1, 0, 0);
      #2 check("src_rs3_stall", stall, 1);
      step();
      id_in(1, 9, 9, 9, 3'b000, 1, 0, 0);
      #2 check("src_unused_stall", stall, 0);
      step();
      id_in(0, 9, 0, 0, 3'b001, 1, 0, 0);
      #2 check("src_invalid_stall", stall, 0);
      step();
      check("src_cnt", stall_cnt, 4);
      clr_in();
      wb_in(9);
      step();
      clr_in();
      check("src_busy_clear", busy_regs, 16'h0000);

      // ---- branch squash: hazarding write to r5 in ID while EX branches
      id_in(1, 0, 0, 0, 3'b000, 2, 1, 0);
      step();
      id_in(1, 2, 0, 0, 3'b001, 5, 1, 0);
      branch_taken_ex = 1'b1;
      #2;
      check("br_flush", flush_if_id, 1);
      check("br_bubble", bubble_id_ex, 1);
      check("br_stall", stall, 0);
      step();
      check("br_busy_no_r5", busy_regs, 16'h0004);
      check("br_cnt", stall_cnt, 4);
      clr_in();
      wb_in(2);
      step();
      clr_in();

      // ---- set/clear race on r4: set wins
      id_in(1, 0, 0, 0, 3'b000, 4, 1, 0);
      step();
      id_in(1, 0, 0, 0, 3'b000, 4, 1, 0);
      wb_in(4);
      step();
      check("race_busy_r4", busy_regs, 16'h0010);
      clr_in();
      wb_in(4);
      step();
      clr_in();
      check("race_clear", busy_regs, 16'h0000);

      // ---- HALT squashed by a taken branch stays in RUN
      id_in(1, 0, 0, 0, 3'b000, 0, 0, 1);
      branch_taken_ex = 1'b1;
      #2;
      check("hsq_stop", stop, 0);
      check("hsq_flush", flush_if_id, 1);
      step();
      clr_in();
      #2;
      check("hsq_after_stop", stop, 0);
      check("hsq_after_flush", flush_if_id, 0);

      // ---- HALT drain with r7 pending, r7 written back two cycles after HALT
      id_in(1, 0, 0, 0, 3'b000, 7, 1, 0);
      step();
      check("halt_busy_r7", busy_regs, 16'h0080);
      id_in(1, 0, 0, 0, 3'b000, 0, 0, 1);
      #2;
      check("halt_issue_stop", stop, 0);
      check("halt_issue_stall", stall, 0);
      step();
      // DRAIN cycle 1: a hazarding write plus a branch must be ignored
      clr_in();
      id_in(1, 7, 0, 0, 3'b001, 3, 1, 0);
      branch_taken_ex = 1'b1;
      #2;
      check("drain1_stop", stop, 1);
      check("drain1_flush", flush_if_id, 1);
      check("drain1_bubble", bubble_id_ex, 1);
      check("drain1_stall", stall, 0);
      check("drain1_halted", halted, 0);
      step();
      // DRAIN cycle 2: WB of r7
      clr_in();
      wb_in(7);
      #2;
      check("drain2_halted", halted, 0);
      check("drain2_stop", stop, 1);
      step();
      // DRAIN cycle 3
      clr_in();
      #2;
      check("drain3_busy", busy_regs, 16'h0000);
      check("drain3_halted", halted, 0);
      check("drain3_cnt", stall_cnt, 4);
      step();
      check("halted_enter", halted, 1);
      check("halted_stop", stop, 1);
      check("halted_flush", flush_if_id, 1);
      check("halted_bubble", bubble_id_ex, 1);
      check("halted_stall", stall, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         check("halted_persist", halted, 1);
      end

      // ---- reset out of HALTED
      rst = 1'b1;
      #2;
      check("hrst_halted_gated", halted, 0);
      check("hrst_stop_gated", stop, 0);
      step();
      rst = 1'b0;
      #2;
      check("hrst_halted", halted, 0);
      check("hrst_stop", stop, 0);
      check("hrst_flush", flush_if_id, 0);

      // ---- reset mid-DRAIN clears scoreboard and stall counter
      id_in(1, 0, 0, 0, 3'b000, 8, 1, 0);
      step();
      id_in(1, 8, 0, 0, 3'b001, 1, 0, 0);
      #2 check("mrst_pre_stall", stall, 1);
      step();
      check("mrst_pre_cnt", stall_cnt, 1);
      id_in(1, 0, 0, 0, 3'b000, 0, 0, 1);
      step();
      clr_in();
      #2 check("mrst_drain_stop", stop, 1);
      step();
      rst = 1'b1;
      #2 check("mrst_stop_gated", stop, 0);
      step();
      rst = 1'b0;
      #2;
      check("mrst_stop", stop, 0);
      check("mrst_halted", halted, 0);
      check("mrst_busy", busy_regs, 16'h0000);
      check("mrst_cnt", stall_cnt, 0);
      id_in(1, 0, 0, 0, 3'b000, 1, 1, 0);
      step();
      clr_in();
      check("mrst_run_issue", busy_regs, 16'h0002);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
